adc_sched: RTL

ADC_SCHED -- requirements
Module: adc_sched

---
 rtl/adc_sched_pkg.sv | 32 +++
 rtl/adc_rr_arb.sv | 31 +++
 rtl/adc_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// -----------------------------------------------------------------------------
// adc_sched_pkg
// Shared definitions for the ADC conversion scheduler:
//   - FSM state encoding (IDLE / CONV / GAP)
//   - conversion owner encoding (SOL = 0, BB = 1)
//   - default timeout and inter-conversion gap lengths
// -----------------------------------------------------------------------------
package adc_sched_pkg;

  localparam int ADC_W = 12;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_SOL = 1'b0,
    OWN_BB  = 1'b1
  } owner_t;

  localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd1200;
  localparam logic [3:0]  DEF_GAP_CYC     = 4'd4;

  // BB conversions use the slow ADC mode, SOL conversions the fast one.
  function automatic logic owner_is_slow(input owner_t owner);
    return (owner == OWN_BB);
  endfunction

endpackage

// File: rtl/adc_rr_arb.sv
// -----------------------------------------------------------------------------
// adc_rr_arb
// Two-way round-robin arbiter, purely combinational. The history bit
// (last_owner) lives in the caller so it only advances on an actual grant.
// Ports:
//   req[1:0]   in  request vector, bit 0 = SOL, bit 1 = BB
//   last_owner in  owner of the previous grant
//   gnt_valid  out at least one request present
//   gnt_owner  out winning requester (only meaningful with gnt_valid)
// -----------------------------------------------------------------------------
module adc_rr_arb
  import adc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       gnt_valid,
  output owner_t     gnt_owner
);

  always_comb begin
    gnt_valid = |req;
    gnt_owner = OWN_SOL;
    if (req == 2'b11) begin
      // Tie: whoever was not served last goes first.
      gnt_owner = (last_owner == OWN_SOL) ? OWN_BB : OWN_SOL;
    end else if (req[1]) begin
      gnt_owner = OWN_BB;
    end
  end

endmodule

// File: rtl/adc_sched.sv
// -----------------------------------------------------------------------------
// adc_sched
// Schedules conversions on a single ADC between two requesters (SOL fast,
// BB slow). One conversion at a time: IDLE -> CONV -> GAP -> IDLE. Each
// conversion ends with exactly one result pulse (val) or timeout pulse (err)
// to its owner, followed by a forced idle gap before the next grant.
// Parameters:
//   TIMEOUT_CYC  max CONV cycles waiting for adc_data_val
//   GAP_CYC      idle cycles between conversions (2..15)
// Ports:
//   tx_clk, tx_rst        clock, synchronous active-high reset
//   sched_en              allow new grants
//   sol_req / bb_req      level requests
//   sol_val / bb_val      result-valid pulses
//   sol_data / bb_data    last captured result per requester
//   sol_err / bb_err      timeout pulses
//   adc_convert           convert request to the ADC
//   convert_slow          1 = slow (BB) conversion
//   adc_data, adc_data_val ADC result and its valid level
//   busy                  FSM not in IDLE
//   conv_cnt              successful conversion count (wrapping)
// -----------------------------------------------------------------------------
module adc_sched
  import adc_sched_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [3:0]  GAP_CYC     = DEF_GAP_CYC
) (
  input  logic              tx_clk,
  input  logic              tx_rst,
  input  logic              sched_en,
  input  logic              sol_req,
  input  logic              bb_req,
  output logic              sol_val,
  output logic              bb_val,
  output logic [ADC_W-1:0]  sol_data,
  output logic [ADC_W-1:0]  bb_data,
  output logic              sol_err,
  output logic              bb_err,
  output logic              adc_convert,
  output logic              convert_slow,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_data_val,
  output logic              busy,
  output logic [CNT_W-1:0]  conv_cnt
);

  localparam logic [15:0] TMO_LAST = TIMEOUT_CYC - 16'd1;
  localparam logic [3:0]  GAP_LAST = GAP_CYC - 4'd1;

  state_t            state_reg;
  owner_t            owner_reg;
  owner_t            last_owner_reg;
  logic [15:0]       tmo_cnt_reg;
  logic [3:0]        gap_cnt_reg;
  logic              adc_convert_reg;
  logic              convert_slow_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  conv_cnt_reg;

  logic              gnt_valid;
  owner_t            gnt_owner;
  logic              conv_done;
  logic              conv_tmo;

  adc_rr_arb u_arb (
    .req        ({bb_req, sol_req}),
    .last_owner (last_owner_reg),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // End-of-conversion events; adc_data_val outside CONV is ignored, and a
  // result arriving on the last allowed cycle beats the timeout.
  assign conv_done = (state_reg == ST_CONV) && adc_data_val;
  assign conv_tmo  = (state_reg == ST_CONV) && !adc_data_val &&
                     (tmo_cnt_reg == TMO_LAST);

  // Main scheduler FSM with registered outputs.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_reg        <= ST_IDLE;
      owner_reg        <= OWN_SOL;
      last_owner_reg   <= OWN_BB;
      tmo_cnt_reg      <= '0;
      gap_cnt_reg      <= '0;
      adc_convert_reg  <= 1'b0;
      convert_slow_reg <= 1'b0;
      busy_reg         <= 1'b0;
      conv_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sched_en && gnt_valid) begin
            state_reg        <= ST_CONV;
            busy_reg         <= 1'b1;
            owner_reg        <= gnt_owner;
            last_owner_reg   <= gnt_owner;
            adc_convert_reg  <= 1'b1;
            convert_slow_reg <= owner_is_slow(gnt_owner);
            tmo_cnt_reg      <= '0;
          end
        end

        ST_CONV: begin
          if (conv_done) begin
            state_reg       <= ST_GAP;
            adc_convert_reg <= 1'b0;
            conv_cnt_reg    <= conv_cnt_reg + 1'b1;
            gap_cnt_reg     <= '0;
          end else if (conv_tmo) begin
            state_reg       <= ST_GAP;
            adc_convert_reg <= 1'b0;
            gap_cnt_reg     <= '0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
        end

        ST_GAP: begin
          // convert_slow is deliberately left alone here so it stays stable
          // into the gap; it is only rewritten on the next grant.
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end

        default: begin
          state_reg       <= ST_IDLE;
          busy_reg        <= 1'b0;
          adc_convert_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester result channels. Channel gi belongs to owner gi; the
  // pulses are mutually exclusive because only the current owner matches.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam owner_t CH_OWNER = (gi == 0) ? OWN_SOL : OWN_BB;

    logic             val_reg;
    logic             err_reg;
    logic [ADC_W-1:0] data_reg;
    logic             mine;

    assign mine = (owner_reg == CH_OWNER);

    always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
        val_reg  <= 1'b0;
        err_reg  <= 1'b0;
        data_reg <= '0;
      end else begin
        val_reg <= conv_done && mine;
        err_reg <= conv_tmo && mine;
        if (conv_done && mine) begin
          data_reg <= adc_data;
        end
      end
    end
  end

  assign sol_val      = g_ch[0].val_reg;
  assign sol_err      = g_ch[0].err_reg;
  assign sol_data     = g_ch[0].data_reg;
  assign bb_val       = g_ch[1].val_reg;
  assign bb_err       = g_ch[1].err_reg;
  assign bb_data      = g_ch[1].data_reg;
  assign adc_convert  = adc_convert_reg;
  assign convert_slow = convert_slow_reg;
  assign busy         = busy_reg;
  assign conv_cnt     = conv_cnt_reg;

endmodule
